// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and ratio helpers for multi_clock_divider
package clkdiv_pkg;

    localparam int MIN_DIV = 2;

    // Ratios 0 and 1 cannot produce a clock, so they are raised to MIN_DIV.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    // Number of high cycles in a period of d cycles: ceil(d/2).
    function automatic logic [31:0] high_time(input logic [31:0] d);
        return (d >> 1) + {31'b0, d[0]};
    endfunction

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel; restart input present under CLKDIV_SYNC_RESTART_EN
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_RESTART_EN
    input  logic             restart,
`endif
    output logic             slower_clk,
    output logic             tick
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend_valid;

    logic [DIV_W-1:0] wr_div_c;
    logic [DIV_W-1:0] half_div;
    logic [DIV_W-1:0] cnt_inc;
    logic             wrap;

    // Clamped write value, high-time of the running ratio and the wrap condition.
    always_comb begin
        wr_div_c = DIV_W'(clamp_div(32'(wr_div)));
        half_div = DIV_W'(high_time(32'(active_div)));
        cnt_inc  = cnt + ONE;
        wrap     = (cnt == active_div - ONE);
    end

    // Counter, ratio bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= RST_DIV - ONE;
            active_div <= RST_DIV;
            pend_div   <= RST_DIV;
            pend_valid <= 1'b0;
            slower_clk <= 1'b0;
            tick       <= 1'b0;
        end else begin
`ifdef CLKDIV_SYNC_RESTART_EN
            if (restart) begin
                // Pending ratio takes effect now; every channel re-arms in lockstep.
                if (pend_valid) begin
                    active_div <= pend_div;
                    cnt        <= pend_div - ONE;
                end else begin
                    cnt        <= active_div - ONE;
                end
                pend_valid <= 1'b0;
                slower_clk <= 1'b0;
                tick       <= 1'b0;
                if (wr) begin
                    pend_div   <= wr_div_c;
                    pend_valid <= 1'b1;
                end
            end else
`endif
            if (!en) begin
                // Idle: outputs low, counter armed so enable ticks on its first edge.
                slower_clk <= 1'b0;
                tick       <= 1'b0;
                if (wr) begin
                    active_div <= wr_div_c;
                    pend_div   <= wr_div_c;
                    cnt        <= wr_div_c - ONE;
                    pend_valid <= 1'b0;
                end else begin
                    cnt        <= active_div - ONE;
                end
            end else begin
                if (wrap) begin
                    cnt        <= '0;
                    tick       <= 1'b1;
                    slower_clk <= 1'b1;
                    if (pend_valid) begin
                        active_div <= pend_div;
                        pend_valid <= 1'b0;
                    end
                end else begin
                    cnt        <= cnt_inc;
                    tick       <= 1'b0;
                    slower_clk <= (cnt_inc < half_div);
                end
                // A write lands after the wrap has consumed the older pending value.
                if (wr) begin
                    pend_div   <= wr_div_c;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - NUM_CH programmable clock dividers; sync_restart port under CLKDIV_SYNC_RESTART_EN
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 5,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_RESTART_EN
    input  logic              sync_restart,
`endif
    output logic [NUM_CH-1:0] slower_clk,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Out-of-range channel numbers match no channel, so such writes vanish.
        assign wr_sel[c] = wr_en && (wr_ch == CH_W'(c));

        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (ch_en[c]),
            .wr         (wr_sel[c]),
            .wr_div     (wr_div),
`ifdef CLKDIV_SYNC_RESTART_EN
            .restart    (sync_restart),
`endif
            .slower_clk (slower_clk[c]),
            .tick       (tick[c])
        );
    end

endmodule
